// File: rtl/exboard_pkg.sv
// Shared types and widths for the exboard sensor emulator.
package exboard_pkg;

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned SAMP_W = 12;
  localparam int unsigned WCNT_W = 16;
  localparam int unsigned BLEN_W = 8;

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  // Window length in ticks is samp+1, which needs one extra bit.
  function automatic logic [SAMP_W:0] win_len(input logic [SAMP_W-1:0] samp);
    return {1'b0, samp} + (SAMP_W+1)'(1);
  endfunction

  function automatic logic [SAMP_W:0] low_eff(input logic [SAMP_W-1:0] low,
                                              input logic [SAMP_W-1:0] samp);
    return ({1'b0, low} > win_len(samp)) ? win_len(samp) : {1'b0, low};
  endfunction

  function automatic logic low_clamped(input logic [SAMP_W-1:0] low,
                                       input logic [SAMP_W-1:0] samp);
    return {1'b0, low} > win_len(samp);
  endfunction

endpackage

// File: rtl/exboard_tick_div.sv
// Clock-enable divider: tick high for one clk every div+1 clks.
module exboard_tick_div
  import exboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  // >= rather than == so a live divisor lowered below the count recovers at once.
  assign tick = (cnt_q >= div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/exboard_sensor_gen.sv
// Emulated deflection/border sensor generator: back-to-back sample windows
// with programmable low times per channel, plus a retriggerable border pulse.
module exboard_sensor_gen
  import exboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_reg,
  input  logic [SAMP_W-1:0] samp_reg,
  input  logic [SAMP_W-1:0] lowA_reg,
  input  logic [SAMP_W-1:0] lowB_reg,
  input  logic              border_req,
  input  logic [BLEN_W-1:0] border_len,
  output logic              deflectionA_out,
  output logic              deflectionB_out,
  output logic              borderA_out,
  output logic              borderB_out,
  output logic              window_done,
  output logic [WCNT_W-1:0] win_cnt,
  output logic              busy,
  output logic              cfg_clamp
);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_sh_q, div_sh_d;
  logic [SAMP_W-1:0] samp_sh_q, samp_sh_d;
  logic [SAMP_W:0]   lowa_q, lowa_d, lowb_q, lowb_d;
  logic [SAMP_W-1:0] tcnt_q, tcnt_d;
  logic              defl_a_q, defl_a_d, defl_b_q, defl_b_d;
  logic              done_q, end_win;
  logic [WCNT_W-1:0] win_cnt_q;
  logic              busy_q, clamp_q, clamp_d;
  logic [BLEN_W-1:0] bcnt_q, bcnt_d;
  logic              border_q;
  logic              wtick, btick, bstart;
  logic [DIV_W-1:0]  bdiv;

  exboard_tick_div u_win_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != StRun),
    .div  (div_sh_q),
    .tick (wtick)
  );

  // Border timebase follows the live divider when no window holds a shadow.
  assign bdiv   = (state_q == StRun) ? div_sh_q : div_reg;
  assign bstart = border_req && (border_len != '0);

  exboard_tick_div u_border_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (bstart),
    .div  (bdiv),
    .tick (btick)
  );

  always_comb begin
    state_d   = state_q;
    div_sh_d  = div_sh_q;
    samp_sh_d = samp_sh_q;
    lowa_d    = lowa_q;
    lowb_d    = lowb_q;
    tcnt_d    = tcnt_q;
    clamp_d   = clamp_q;
    end_win   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StLoad;
      end
      StLoad: begin
        state_d   = StRun;
        div_sh_d  = div_reg;
        samp_sh_d = samp_reg;
        lowa_d    = low_eff(lowA_reg, samp_reg);
        lowb_d    = low_eff(lowB_reg, samp_reg);
        clamp_d   = low_clamped(lowA_reg, samp_reg) || low_clamped(lowB_reg, samp_reg);
        tcnt_d    = '0;
      end
      StRun: begin
        if (wtick) begin
          if (tcnt_q == samp_sh_q) begin
            end_win = 1'b1;
            tcnt_d  = '0;
            state_d = enable ? StLoad : StIdle;
          end else begin
            tcnt_d = tcnt_q + SAMP_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lines are computed from next-state values so the register matches the
  // coming clk; LOAD holds them so a fully-low channel never glitches high.
  always_comb begin
    defl_a_d = 1'b1;
    defl_b_d = 1'b1;
    if (state_d == StLoad) begin
      defl_a_d = defl_a_q;
      defl_b_d = defl_b_q;
    end else if (state_d == StRun) begin
      defl_a_d = ({1'b0, tcnt_d} >= lowa_d);
      defl_b_d = ({1'b0, tcnt_d} >= lowb_d);
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    if (bstart) begin
      bcnt_d = border_len;
    end else if (btick && (bcnt_q != '0)) begin
      bcnt_d = bcnt_q - BLEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      div_sh_q  <= '0;
      samp_sh_q <= '0;
      lowa_q    <= '0;
      lowb_q    <= '0;
      tcnt_q    <= '0;
      defl_a_q  <= 1'b1;
      defl_b_q  <= 1'b1;
      done_q    <= 1'b0;
      win_cnt_q <= '0;
      busy_q    <= 1'b0;
      clamp_q   <= 1'b0;
      bcnt_q    <= '0;
      border_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_sh_q  <= div_sh_d;
      samp_sh_q <= samp_sh_d;
      lowa_q    <= lowa_d;
      lowb_q    <= lowb_d;
      tcnt_q    <= tcnt_d;
      defl_a_q  <= defl_a_d;
      defl_b_q  <= defl_b_d;
      done_q    <= end_win;
      win_cnt_q <= win_cnt_q + WCNT_W'(end_win);
      busy_q    <= (state_d != StIdle);
      clamp_q   <= clamp_d;
      bcnt_q    <= bcnt_d;
      border_q  <= (bcnt_d != '0);
    end
  end

  assign deflectionA_out = defl_a_q;
  assign deflectionB_out = defl_b_q;
  assign borderA_out     = border_q;
  assign borderB_out     = 1'b0;
  assign window_done     = done_q;
  assign win_cnt         = win_cnt_q;
  assign busy            = busy_q;
  assign cfg_clamp       = clamp_q;

endmodule
